// File: rtl/pipeline_mem_pkg.sv
// Shared definitions for the fetch-stage memory port: responder states,
// default bus widths and the latency counter width.
package pipeline_mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK,
        RELEASE
    } state_t;

endpackage

// File: rtl/pipeline_mem_ram.sv
// Single-port synchronous RAM with registered read and no reset.
// A read on the same edge as a write returns the old contents.
module pipeline_mem_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pipeline_mem_responder.sv
// Memory-side responder: captures one request, commits writes at capture,
// acks after a fixed latency and waits for the requester to drop mem_en.
module pipeline_mem_responder
    import pipeline_mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_di,
    input  logic              mem_en,
    input  logic              mem_we,
    output logic [DATA_W-1:0] mem_do,
    output logic              do_ack,
    output logic              mem_err,
    output logic              busy
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]  cnt;
    logic [RAM_AW-1:0] addr_q;
    logic              we_q;
    logic              in_range_q;

    logic              req_in_range;
    logic              capture;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign req_in_range = ({1'b0, mem_addr} < DEPTH_X);
    assign capture      = (state == IDLE) && mem_en;
    assign ram_we       = capture && mem_we && req_in_range;
    // In IDLE the RAM looks at the live address so read data is already
    // registered one edge after capture, which makes LATENCY=1 work.
    assign ram_addr     = (state == IDLE) ? mem_addr[RAM_AW-1:0] : addr_q;
    assign busy         = (state != IDLE);

    pipeline_mem_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (mem_di),
        .rdata (ram_rdata)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (mem_en) begin
                    next_state = (LATENCY == 1) ? ACK : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = RELEASE;
            end
            RELEASE: begin
                if (!mem_en) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            in_range_q <= 1'b1;
        end else begin
            state <= next_state;
            if (capture) begin
                addr_q     <= mem_addr[RAM_AW-1:0];
                we_q       <= mem_we;
                in_range_q <= req_in_range;
                cnt        <= CNT_LOAD;
            end else if (state == ACCESS) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Outputs register while leaving ACK, so the ack lands LATENCY edges after capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_do  <= '0;
            do_ack  <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            do_ack  <= (state == ACK);
            mem_err <= (state == ACK) && !in_range_q;
            if ((state == ACK) && !we_q) begin
                mem_do <= in_range_q ? ram_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mem_responder.sv
// Directed bench for pipeline_mem_responder across four parameter builds
// sharing one clock, reset and request bus; each build has its own mem_en.
module tb_pipeline_mem_responder;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] addr  = 8'h00;
    logic [7:0] din   = 8'h00;
    logic       we    = 1'b0;

    logic       en   [4];
    logic       ack  [4];
    logic       err  [4];
    logic       busy [4];
    logic [7:0] dout [4];

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    int         lat;
    int         extra;
    logic [7:0] rd;
    logic       er;
    logic       held_busy;

    always #5 clk = ~clk;

    pipeline_mem_responder #(.LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .mem_addr(addr), .mem_di(din), .mem_en(en[0]), .mem_we(we),
        .mem_do(dout[0]), .do_ack(ack[0]), .mem_err(err[0]), .busy(busy[0])
    );

    pipeline_mem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .mem_addr(addr), .mem_di(din), .mem_en(en[1]), .mem_we(we),
        .mem_do(dout[1]), .do_ack(ack[1]), .mem_err(err[1]), .busy(busy[1])
    );

    pipeline_mem_responder #(.LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .mem_addr(addr), .mem_di(din), .mem_en(en[2]), .mem_we(we),
        .mem_do(dout[2]), .do_ack(ack[2]), .mem_err(err[2]), .busy(busy[2])
    );

    pipeline_mem_responder #(.DEPTH(128), .LATENCY(3)) u_d128 (
        .clk(clk), .reset(reset), .mem_addr(addr), .mem_di(din), .mem_en(en[3]), .mem_we(we),
        .mem_do(dout[3]), .do_ack(ack[3]), .mem_err(err[3]), .busy(busy[3])
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full handshake: raise en, wait (bounded) for ack, hold en for
    // 'hold' extra cycles, drop it and let RELEASE sample the low level.
    task automatic apply_stimulus(input int d, input logic [7:0] a, input logic [7:0] di,
                                  input logic w, input int hold,
                                  output int l, output logic [7:0] r, output logic e,
                                  output int x, output logic hb);
        @(negedge clk);
        addr  = a;
        din   = di;
        we    = w;
        en[d] = 1'b1;
        @(negedge clk);
        l = 0;
        while (!ack[d] && l < 40) begin
            @(negedge clk);
            l++;
        end
        r  = dout[d];
        e  = err[d];
        x  = 0;
        hb = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ack[d]) x++;
            hb = hb & busy[d];
        end
        en[d] = 1'b0;
        addr  = 8'hEE;
        din   = 8'hEE;
        we    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) en[i] = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check_output("rst_ack",  ack[0],  1'b0);
        check_output("rst_err",  err[0],  1'b0);
        check_output("rst_busy", busy[0], 1'b0);
        check_output("rst_do",   dout[0], 8'h00);
        reset = 1'b1;

        // Write then read back on the default LATENCY=2 build
        apply_stimulus(0, 8'h10, 8'h5A, 1'b1, 0, lat, rd, er, extra, held_busy);
        check_output("wr_lat",  lat, 2);
        check_output("wr_err",  er, 1'b0);
        check_output("wr_idle", busy[0], 1'b0);
        apply_stimulus(0, 8'h10, 8'h00, 1'b0, 0, lat, rd, er, extra, held_busy);
        check_output("rd_lat",  lat, 2);
        check_output("rd_data", rd, 8'h5A);
        check_output("rd_err",  er, 1'b0);
        repeat (5) @(negedge clk);
        check_output("rd_hold", dout[0], 8'h5A);

        // Requester keeps en high three cycles past the ack
        apply_stimulus(0, 8'h10, 8'h00, 1'b0, 3, lat, rd, er, extra, held_busy);
        check_output("rel_extra_ack", extra, 0);
        check_output("rel_busy",      held_busy, 1'b1);
        check_output("rel_idle",      busy[0], 1'b0);

        // LATENCY=1 build
        apply_stimulus(1, 8'h03, 8'hC3, 1'b1, 0, lat, rd, er, extra, held_busy);
        check_output("l1_wr_lat", lat, 1);
        apply_stimulus(1, 8'h03, 8'h00, 1'b0, 0, lat, rd, er, extra, held_busy);
        check_output("l1_rd_lat",  lat, 1);
        check_output("l1_rd_data", rd, 8'hC3);

        // LATENCY=4 build
        apply_stimulus(2, 8'h05, 8'h77, 1'b1, 0, lat, rd, er, extra, held_busy);
        check_output("l4_wr_lat", lat, 4);
        apply_stimulus(2, 8'h05, 8'h00, 1'b0, 0, lat, rd, er, extra, held_busy);
        check_output("l4_rd_lat",  lat, 4);
        check_output("l4_rd_data", rd, 8'h77);

        // DEPTH=128 build: out-of-range read and write (0x90 aliases 0x10 if truncated)
        apply_stimulus(3, 8'h10, 8'h11, 1'b1, 0, lat, rd, er, extra, held_busy);
        apply_stimulus(3, 8'h10, 8'h00, 1'b0, 0, lat, rd, er, extra, held_busy);
        check_output("d128_rd_data", rd, 8'h11);
        apply_stimulus(3, 8'h80, 8'h00, 1'b0, 0, lat, rd, er, extra, held_busy);
        check_output("oor_rd_lat",  lat, 3);
        check_output("oor_rd_err",  er, 1'b1);
        check_output("oor_rd_data", rd, 8'h00);
        apply_stimulus(3, 8'h90, 8'hFF, 1'b1, 0, lat, rd, er, extra, held_busy);
        check_output("oor_wr_err", er, 1'b1);
        apply_stimulus(3, 8'h10, 8'h00, 1'b0, 0, lat, rd, er, extra, held_busy);
        check_output("oor_wr_nochange", rd, 8'h11);
        check_output("inr_rd_err",      er, 1'b0);

        // en dropped and address changed one cycle after capture (LATENCY=3)
        apply_stimulus(3, 8'h05, 8'h66, 1'b1, 0, lat, rd, er, extra, held_busy);
        apply_stimulus(3, 8'h20, 8'h99, 1'b1, 0, lat, rd, er, extra, held_busy);
        @(negedge clk);
        addr  = 8'h05;
        we    = 1'b0;
        en[3] = 1'b1;
        @(negedge clk);
        en[3] = 1'b0;
        addr  = 8'h20;
        lat   = 0;
        while (!ack[3] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_output("drop_lat",  lat, 3);
        check_output("drop_data", dout[3], 8'h66);
        @(negedge clk);
        check_output("drop_idle", busy[3], 1'b0);

        // Reset in the middle of a write's ACCESS phase
        @(negedge clk);
        addr  = 8'h20;
        din   = 8'h3C;
        we    = 1'b1;
        en[0] = 1'b1;
        @(negedge clk);
        check_output("mid_busy", busy[0], 1'b1);
        #2;
        reset = 1'b0;
        en[0] = 1'b0;
        we    = 1'b0;
        #1;
        check_output("mid_rst_ack",  ack[0],  1'b0);
        check_output("mid_rst_busy", busy[0], 1'b0);
        check_output("mid_rst_do",   dout[0], 8'h00);
        @(negedge clk);
        reset = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack[0]) extra++;
        end
        check_output("mid_no_ack", extra, 0);
        apply_stimulus(0, 8'h20, 8'h00, 1'b0, 0, lat, rd, er, extra, held_busy);
        check_output("mid_wr_kept", rd, 8'h3C);
        check_output("mid_rd_lat",  lat, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
